// File: rtl/dla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dla_pkg
//  Description : Shared tile-controller types: FSM states, tile_loc bit
//                positions and default field widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package dla_pkg;

    localparam int c_dim_width_def      = 15;
    localparam int c_tile_cnt_width_def = 6;

    localparam int c_loc_top    = 3;
    localparam int c_loc_bottom = 2;
    localparam int c_loc_left   = 1;
    localparam int c_loc_right  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } tile_state_t;

endpackage : dla_pkg
`default_nettype wire

// File: rtl/tile_geom_calc.sv
`default_nettype none
// ============================================================================
//  Module      : tile_geom_calc
//  Description : Input-tile extent for one axis from kernel size and borders.
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_geom_calc
    import dla_pkg::*;
#(
    parameter int DIM_WIDTH = c_dim_width_def
) (
    input  logic [3:0]           ksize,
    input  logic [DIM_WIDTH-1:0] out_size,
    input  logic                 first,
    input  logic                 last,
    output logic [DIM_WIDTH-1:0] in_size
);

    logic [3:0]           w_pad;
    logic [DIM_WIDTH-1:0] w_halo;

    // Border tiles drop the halo on the side that falls outside the image.
    always_comb begin
        w_pad   = (ksize - 4'd1) >> 1;
        w_halo  = DIM_WIDTH'(ksize) - DIM_WIDTH'(1)
                - (first ? DIM_WIDTH'(w_pad) : '0)
                - (last  ? DIM_WIDTH'(w_pad) : '0);
        in_size = out_size + w_halo;
    end

endmodule : tile_geom_calc
`default_nettype wire

// File: rtl/tile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tile_ctrl
//  Description : Walks a layer's tile grid in raster order, issuing per-tile
//                geometry and start pulses to the scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_ctrl
    import dla_pkg::*;
#(
    parameter int DIM_WIDTH      = c_dim_width_def,
    parameter int TILE_CNT_WIDTH = c_tile_cnt_width_def
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      layer_start,
    input  logic [TILE_CNT_WIDTH-1:0] cfg_h_tiles,
    input  logic [TILE_CNT_WIDTH-1:0] cfg_w_tiles,
    input  logic [3:0]                cfg_ksize,
    input  logic [DIM_WIDTH-1:0]      cfg_tile_out_h,
    input  logic [DIM_WIDTH-1:0]      cfg_tile_out_w,
    input  logic [DIM_WIDTH-1:0]      cfg_tile_in_c,
    input  logic [DIM_WIDTH-1:0]      cfg_tile_out_c,
    input  logic                      sch_tile_done,
    output logic                      ctrl2sch_layer_start,
    output logic                      tile_switch,
    output logic [3:0]                tile_loc,
    output logic [3:0]                ksize,
    output logic [DIM_WIDTH-1:0]      tile_in_h,
    output logic [DIM_WIDTH-1:0]      tile_out_h,
    output logic [DIM_WIDTH-1:0]      tile_in_w,
    output logic [DIM_WIDTH-1:0]      tile_out_w,
    output logic [DIM_WIDTH-1:0]      tile_in_c,
    output logic [DIM_WIDTH-1:0]      tile_out_c,
    output logic [3:0]                cnt_layer,
    output logic                      busy,
    output logic                      layer_done
);

    tile_state_t               r_state;
    tile_state_t               w_next;
    logic [TILE_CNT_WIDTH-1:0] r_h_tiles;
    logic [TILE_CNT_WIDTH-1:0] r_w_tiles;
    logic [TILE_CNT_WIDTH-1:0] r_row;
    logic [TILE_CNT_WIDTH-1:0] r_col;
    logic                      w_last_row;
    logic                      w_last_col;
    logic                      w_last_tile;
    logic [3:0]                w_loc;
    logic [DIM_WIDTH-1:0]      w_in_h;
    logic [DIM_WIDTH-1:0]      w_in_w;

    always_comb begin
        w_last_row          = (r_row == r_h_tiles - TILE_CNT_WIDTH'(1));
        w_last_col          = (r_col == r_w_tiles - TILE_CNT_WIDTH'(1));
        w_last_tile         = w_last_row && w_last_col;
        w_loc               = '0;
        w_loc[c_loc_top]    = (r_row == '0);
        w_loc[c_loc_bottom] = w_last_row;
        w_loc[c_loc_left]   = (r_col == '0);
        w_loc[c_loc_right]  = w_last_col;
    end

    tile_geom_calc #(.DIM_WIDTH(DIM_WIDTH)) u_geom_h (
        .ksize    (ksize),
        .out_size (tile_out_h),
        .first    (w_loc[c_loc_top]),
        .last     (w_loc[c_loc_bottom]),
        .in_size  (w_in_h)
    );

    tile_geom_calc #(.DIM_WIDTH(DIM_WIDTH)) u_geom_w (
        .ksize    (ksize),
        .out_size (tile_out_w),
        .first    (w_loc[c_loc_left]),
        .last     (w_loc[c_loc_right]),
        .in_size  (w_in_w)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (layer_start)   w_next = ST_LOAD;
            ST_LOAD:                     w_next = ST_START;
            ST_START:                    w_next = ST_RUN;
            ST_RUN:   if (sch_tile_done) w_next = ST_NEXT;
            ST_NEXT:  w_next = w_last_tile ? ST_DONE : ST_LOAD;
            ST_DONE:                     w_next = ST_IDLE;
            default:                     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_h_tiles            <= '0;
            r_w_tiles            <= '0;
            r_row                <= '0;
            r_col                <= '0;
            ctrl2sch_layer_start <= 1'b0;
            tile_switch          <= 1'b0;
            tile_loc             <= '0;
            ksize                <= '0;
            tile_in_h            <= '0;
            tile_out_h           <= '0;
            tile_in_w            <= '0;
            tile_out_w           <= '0;
            tile_in_c            <= '0;
            tile_out_c           <= '0;
            cnt_layer            <= '0;
            busy                 <= 1'b0;
            layer_done           <= 1'b0;
        end else begin
            ctrl2sch_layer_start <= (r_state == ST_START);
            tile_switch          <= (r_state == ST_NEXT) && !w_last_tile;
            layer_done           <= (r_state == ST_DONE);

            // busy stays up through the layer_done cycle, unless a new layer restarts it
            if (r_state == ST_IDLE && layer_start) busy <= 1'b1;
            else if (layer_done)                   busy <= 1'b0;

            if (r_state == ST_IDLE && layer_start) begin
                r_h_tiles  <= (cfg_h_tiles == '0) ? TILE_CNT_WIDTH'(1) : cfg_h_tiles;
                r_w_tiles  <= (cfg_w_tiles == '0) ? TILE_CNT_WIDTH'(1) : cfg_w_tiles;
                r_row      <= '0;
                r_col      <= '0;
                ksize      <= cfg_ksize;
                tile_out_h <= cfg_tile_out_h;
                tile_out_w <= cfg_tile_out_w;
                tile_in_c  <= cfg_tile_in_c;
                tile_out_c <= cfg_tile_out_c;
            end

            if (r_state == ST_LOAD) begin
                tile_loc  <= w_loc;
                tile_in_h <= w_in_h;
                tile_in_w <= w_in_w;
            end

            if (r_state == ST_NEXT && !w_last_tile) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + TILE_CNT_WIDTH'(1);
                end else begin
                    r_col <= r_col + TILE_CNT_WIDTH'(1);
                end
            end

            if (r_state == ST_DONE) cnt_layer <= cnt_layer + 4'd1;
        end
    end

endmodule : tile_ctrl
`default_nettype wire

// File: tb/tb_tile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_ctrl
//  Description : Scoreboard bench for tile_ctrl against a grid-walk model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_ctrl;

    localparam int DW = 15;
    localparam int TW = 6;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          layer_start = 1'b0;
    logic          sch_tile_done = 1'b0;
    logic [TW-1:0] cfg_h_tiles = '0, cfg_w_tiles = '0;
    logic [3:0]    cfg_ksize = '0;
    logic [DW-1:0] cfg_tile_out_h = '0, cfg_tile_out_w = '0;
    logic [DW-1:0] cfg_tile_in_c = '0, cfg_tile_out_c = '0;
    logic          ctrl2sch_layer_start, tile_switch, busy, layer_done;
    logic [3:0]    tile_loc, ksize, cnt_layer;
    logic [DW-1:0] tile_in_h, tile_out_h, tile_in_w, tile_out_w, tile_in_c, tile_out_c;

    tile_ctrl #(.DIM_WIDTH(DW), .TILE_CNT_WIDTH(TW)) dut (
        .clk(clk), .rstn(rstn), .layer_start(layer_start),
        .cfg_h_tiles(cfg_h_tiles), .cfg_w_tiles(cfg_w_tiles), .cfg_ksize(cfg_ksize),
        .cfg_tile_out_h(cfg_tile_out_h), .cfg_tile_out_w(cfg_tile_out_w),
        .cfg_tile_in_c(cfg_tile_in_c), .cfg_tile_out_c(cfg_tile_out_c),
        .sch_tile_done(sch_tile_done), .ctrl2sch_layer_start(ctrl2sch_layer_start),
        .tile_switch(tile_switch), .tile_loc(tile_loc), .ksize(ksize),
        .tile_in_h(tile_in_h), .tile_out_h(tile_out_h), .tile_in_w(tile_in_w),
        .tile_out_w(tile_out_w), .tile_in_c(tile_in_c), .tile_out_c(tile_out_c),
        .cnt_layer(cnt_layer), .busy(busy), .layer_done(layer_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    loc;
        logic [3:0]    k;
        logic [DW-1:0] in_h, in_w, out_h, out_w, in_c, out_c;
    } tile_exp_t;

    tile_exp_t  exp_q[$];
    int         done_q[$];
    logic [3:0] loc_obs[$];
    tile_exp_t  mon_e;
    int checks = 0, errors = 0;
    int n_start = 0, n_switch = 0, n_done = 0;
    int model_layers = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: every tile of the grid in raster order, halo trimmed at image borders.
    task automatic push_layer(input int nh, nw, k, oh, ow, ic, oc);
        tile_exp_t e;
        int pad;
        pad = (k - 1) / 2;
        for (int r = 0; r < nh; r++) begin
            for (int c = 0; c < nw; c++) begin
                bit top, bot, lft, rgt;
                top = (r == 0); bot = (r == nh - 1);
                lft = (c == 0); rgt = (c == nw - 1);
                e.loc   = {top, bot, lft, rgt};
                e.k     = 4'(k);
                e.in_h  = DW'((oh + k - 1 - pad * int'(top) - pad * int'(bot)) & 32'h7fff);
                e.in_w  = DW'((ow + k - 1 - pad * int'(lft) - pad * int'(rgt)) & 32'h7fff);
                e.out_h = DW'(oh); e.out_w = DW'(ow);
                e.in_c  = DW'(ic); e.out_c = DW'(oc);
                exp_q.push_back(e);
            end
        end
        model_layers = (model_layers + 1) % 16;
        done_q.push_back(model_layers);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (ctrl2sch_layer_start) begin
                n_start++;
                loc_obs.push_back(tile_loc);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_tile_start: got pulse expected none");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tile_loc",   tile_loc,   mon_e.loc);
                    chk("ksize",      ksize,      mon_e.k);
                    chk("tile_in_h",  tile_in_h,  mon_e.in_h);
                    chk("tile_in_w",  tile_in_w,  mon_e.in_w);
                    chk("tile_out_h", tile_out_h, mon_e.out_h);
                    chk("tile_out_w", tile_out_w, mon_e.out_w);
                    chk("tile_in_c",  tile_in_c,  mon_e.in_c);
                    chk("tile_out_c", tile_out_c, mon_e.out_c);
                    chk("busy_in_tile", busy, 1);
                end
            end
            if (tile_switch) n_switch++;
            if (layer_done) begin
                n_done++;
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_layer_done: got pulse expected none");
                end else begin
                    chk("cnt_layer", cnt_layer, done_q.pop_front());
                end
            end
        end
    end

    task automatic scramble();
        cfg_h_tiles    = TW'($urandom);
        cfg_w_tiles    = TW'($urandom);
        cfg_ksize      = 4'($urandom);
        cfg_tile_out_h = DW'($urandom);
        cfg_tile_out_w = DW'($urandom);
        cfg_tile_in_c  = DW'($urandom);
        cfg_tile_out_c = DW'($urandom);
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!ctrl2sch_layer_start && n < 200) begin
            @(negedge clk); scramble(); n++;
        end
    endtask

    task automatic issue_start(input int h, w, k, oh, ow, ic, oc);
        @(negedge clk);
        cfg_h_tiles = TW'(h); cfg_w_tiles = TW'(w); cfg_ksize = 4'(k);
        cfg_tile_out_h = DW'(oh); cfg_tile_out_w = DW'(ow);
        cfg_tile_in_c = DW'(ic); cfg_tile_out_c = DW'(oc);
        layer_start = 1'b1;
        @(negedge clk);
        layer_start = 1'b0;
        scramble();
    endtask

    task automatic finish_tile(input bit poke);
        @(negedge clk);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (poke) begin
            layer_start = 1'b1; @(negedge clk); layer_start = 1'b0;
        end
        sch_tile_done = 1'b1; @(negedge clk); sch_tile_done = 1'b0;
    endtask

    task automatic run_layer(input int h, w, k, oh, ow, ic, oc, input bit poke);
        int nh, nw, s0, w0, d0, n;
        nh = (h == 0) ? 1 : h;
        nw = (w == 0) ? 1 : w;
        push_layer(nh, nw, k, oh, ow, ic, oc);
        s0 = n_start; w0 = n_switch; d0 = n_done;
        issue_start(h, w, k, oh, ow, ic, oc);
        for (int t = 0; t < nh * nw; t++) begin
            wait_start(n);
            if (n >= 200) begin chk("tile_start_timeout", n, 0); return; end
            if (t == 0) chk("start_latency", n, 2);
            finish_tile(poke && t == 0);
        end
        n = 0;
        while (!layer_done && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin chk("layer_done_timeout", n, 0); return; end
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("start_pulses", n_start - s0, nh * nw);
        chk("switch_pulses", n_switch - w0, nh * nw - 1);
        chk("done_pulses", n_done - d0, 1);
    endtask

    task automatic apply_reset();
        @(posedge clk); #2 rstn = 1'b0;
        exp_q.delete(); done_q.delete(); model_layers = 0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rstn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] seq_exp [6];
        int n;
        seq_exp = '{4'b1010, 4'b1000, 4'b1001, 4'b0110, 4'b0100, 4'b0101};

        repeat (3) @(negedge clk);
        chk("rst_tile_loc", tile_loc, 0);
        chk("rst_cnt_layer", cnt_layer, 0);
        chk("rst_busy", busy, 0);
        chk("rst_misc", {ctrl2sch_layer_start, tile_switch, layer_done, ksize,
                         tile_in_h, tile_in_w, tile_out_h, tile_out_w} != 0, 0);
        @(posedge clk); #2 rstn = 1'b1;

        run_layer(1, 1, 3, 32, 32, 4, 8, 1'b0);
        chk("1x1_cnt_layer", cnt_layer, 1);
        chk("1x1_tile_in_h", tile_in_h, 32);
        chk("1x1_tile_loc", tile_loc, 4'b1111);

        loc_obs.delete();
        run_layer(2, 3, 3, 8, 8, 16, 16, 1'b0);
        chk("2x3_loc_count", loc_obs.size(), 6);
        if (loc_obs.size() == 6)
            for (int i = 0; i < 6; i++) chk("2x3_loc_seq", loc_obs[i], seq_exp[i]);

        run_layer(2, 2, 1, 16, 16, 3, 3, 1'b0);

        @(negedge clk); sch_tile_done = 1'b1; @(negedge clk); sch_tile_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_done_ignored_busy", busy, 0);
        run_layer(2, 2, 5, 40, 12, 7, 9, 1'b1);

        for (int i = 0; i < 8; i++)
            run_layer($urandom_range(0, 3), $urandom_range(0, 3), 2 * $urandom_range(0, 3) + 1,
                      $urandom_range(0, 32767), $urandom_range(0, 32767),
                      $urandom_range(0, 32767), $urandom_range(0, 32767), 1'b0);

        // Abandon a 2x2 layer while the second tile is running.
        push_layer(2, 2, 3, 20, 24, 5, 6);
        issue_start(2, 2, 3, 20, 24, 5, 6);
        wait_start(n);
        finish_tile(1'b0);
        wait_start(n);
        chk("abort_second_tile_seen", ctrl2sch_layer_start, 1);
        @(posedge clk); #2 rstn = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_cnt_layer", cnt_layer, 0);
        chk("abort_outs", {ctrl2sch_layer_start, tile_switch, layer_done, tile_loc, ksize,
                           tile_in_h, tile_in_w, tile_out_h, tile_out_w,
                           tile_in_c, tile_out_c} != 0, 0);
        exp_q.delete(); done_q.delete(); model_layers = 0;
        repeat (3) begin @(negedge clk); chk("abort_no_done", layer_done, 0); end
        @(posedge clk); #2 rstn = 1'b1;
        run_layer(2, 2, 3, 20, 24, 5, 6, 1'b0);

        apply_reset();
        for (int i = 0; i < 16; i++) run_layer(1, 1, 7, 10 + i, 20 + i, i, i, 1'b0);
        chk("cnt_wrap", cnt_layer, 0);

        repeat (5) @(negedge clk);
        chk("leftover_tiles", exp_q.size(), 0);
        chk("leftover_dones", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tile_ctrl
`default_nettype wire

// File: doc/tile_ctrl.md
TILE_CTRL -- requirements
Module: tile_ctrl

Interface
REQ-001 The block SHALL have parameter DIM_WIDTH, default 15, the width of all tile dimension and channel fields.
REQ-002 The block SHALL have parameter TILE_CNT_WIDTH, default 6, the width of the tile-grid counts and indices.
REQ-003 The block SHALL have these ports:
- clk  in  1  the single clock.
- rstn  in  1  reset; asynchronous, active-low.
- layer_start  in  1  one-cycle request to process one layer.
- cfg_h_tiles, cfg_w_tiles  in  TILE_CNT_WIDTH  tile-grid rows and columns; 0 is treated as 1.
- cfg_ksize  in  4  kernel size: 1, 3, 5 or 7.
- cfg_tile_out_h, cfg_tile_out_w  in  DIM_WIDTH  output tile size.
- cfg_tile_in_c, cfg_tile_out_c  in  DIM_WIDTH  channel counts, passed through.
- sch_tile_done  in  1  scheduler has finished the current tile.
- ctrl2sch_layer_start  out  1  one-cycle tile-start pulse to the scheduler.
- tile_switch  out  1  one-cycle pulse when advancing to the next tile of the same layer.
- tile_loc  out  4  border flags: [3] top, [2] bottom, [1] left, [0] right.
- ksize  out  4  latched cfg_ksize.
- tile_in_h, tile_out_h, tile_in_w, tile_out_w, tile_in_c, tile_out_c  out  DIM_WIDTH  per-tile geometry for the scheduler.
- cnt_layer  out  4  number of completed layers, modulo 16.
- busy  out  1  high from the cycle after layer_start is accepted until the cycle after layer_done.
- layer_done  out  1  one-cycle pulse after the last tile completes.

Function
REQ-004 The FSM SHALL have exactly the states IDLE, LOAD, START, RUN, NEXT and DONE.
REQ-005 In IDLE, layer_start SHALL latch every cfg_* input, clear the row index and column index, and move the FSM to LOAD.
REQ-006 layer_start SHALL be ignored in every state other than IDLE.
REQ-007 LOAD SHALL register tile_loc and the tile geometry for the current indices, then move to START.
REQ-008 START SHALL drive ctrl2sch_layer_start high for exactly one cycle, then move to RUN.
REQ-009 Latency: with layer_start sampled high at edge N, ctrl2sch_layer_start SHALL be high in the cycle after edge N+2.
REQ-010 RUN SHALL wait for sch_tile_done, then move to NEXT.
REQ-011 sch_tile_done SHALL be ignored in every state other than RUN.
REQ-012 Tile order SHALL be raster: column index first, then row index.
REQ-013 In NEXT, if the current tile is not the last tile of the grid, the block SHALL pulse tile_switch for one cycle, advance the indices and move to LOAD.
REQ-014 In NEXT, if the current tile is the last tile of the grid, the block SHALL move to DONE.
REQ-015 DONE SHALL pulse layer_done for one cycle, increment cnt_layer (wrapping 15 to 0) and return to IDLE.
REQ-016 tile_loc[3] SHALL be set when row index = 0.
REQ-017 tile_loc[2] SHALL be set when row index = h_tiles-1.
REQ-018 tile_loc[1] SHALL be set when column index = 0.
REQ-019 tile_loc[0] SHALL be set when column index = w_tiles-1.
REQ-020 For a 1x1 grid, all four tile_loc bits SHALL be set.
REQ-021 With pad = (ksize-1)/2, tile_in_h SHALL equal tile_out_h + ksize - 1 - pad*tile_loc[3] - pad*tile_loc[2].
REQ-022 tile_in_w SHALL be computed the same way using tile_out_w, tile_loc[1] and tile_loc[0].
REQ-023 The tile_in_h and tile_in_w results SHALL be truncated to DIM_WIDTH.
REQ-024 tile_out_h, tile_out_w, tile_in_c, tile_out_c and ksize SHALL be the latched configuration values.
REQ-025 All outputs SHALL be registered and SHALL stay stable from LOAD through NEXT.
REQ-026 A change on any cfg_* input while busy is high SHALL have no effect on the current layer.

Reset
REQ-027 When rstn is low, the FSM SHALL be forced to IDLE immediately, regardless of state.
REQ-028 When rstn is low, all outputs, indices and latched configuration SHALL be 0, and any in-progress layer SHALL be abandoned with no layer_done.
REQ-029 After rstn is released, the first rising clock edge SHALL be able to accept layer_start.

Structure
REQ-030 A shared package (dla_pkg) SHALL hold the FSM state encoding, the tile_loc bit positions and the DIM_WIDTH and TILE_CNT_WIDTH defaults.
REQ-031 The block SHALL contain one sub-module, tile_geom_calc: the combinational computation of pad and the in-size for one axis, instantiated twice (h and w).

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- 1x1 grid, ksize=3, out_h=out_w=32 -> one ctrl2sch_layer_start pulse; tile_loc=1111; tile_in_h=tile_in_w=32; layer_done one cycle after NEXT; cnt_layer=1.
- 2x3 grid, ksize=3, out 8x8 -> six start pulses and five tile_switch pulses.
  - tile_loc sequence: 1010, 1000, 1001, 0110, 0100, 0101.
  - First tile: tile_in_h=9, tile_in_w=9.
  - Middle tile (row 0, col 1): tile_in_w=10.
- ksize=1, 2x2 grid, out 16x16 -> every tile has tile_in_h=tile_in_w=16.
- Second layer_start during RUN, plus sch_tile_done asserted in IDLE -> both ignored; exactly one layer_done.
- rstn dropped during RUN of tile 2 of 4 -> all outputs 0 and busy=0 at once; no layer_done; a new layer_start then runs normally from tile 0.
- 16 back-to-back 1x1 layers -> cnt_layer wraps to 0.
